// File: rtl/lab5_mc_alu.sv
// lab5_mc_alu -- small MIPS-style ALU with multi-cycle multiply and an
// optional multi-cycle restoring divider.
//
// Optional feature: define LAB5_MC_ALU_DIV_EN to build the divider and give
// opcodes 1110 (signed) / 1111 (unsigned) their divide meaning. Without the
// macro those two opcodes complete in one edge with hi=0, lo=0.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request, sampled only while busy=0
//   op[3:0]     operation code, sampled with start
//   a, b        WIDTH-bit operands, sampled with start
//   shamt       shift amount, sampled with start
//   hi, lo      registered results (hold between done pulses)
//   zero        high when registered lo == 0
//   busy        high while a multi-cycle op is in RUN or FIN
//   done        one-cycle pulse coincident with new hi/lo
//   dbg_state   current FSM state (IDLE=0, RUN=1, FIN=2)
//
// Handshake: start is a request qualified by busy=0; the op is accepted on the
// rising edge where start=1 and busy=0. Exactly one done pulse follows each
// accepted op, one edge later for single-cycle ops and WIDTH+2 edges later
// for multiply/divide. busy drops in the done cycle, so a new start presented
// there is accepted without an idle gap.
module lab5_mc_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;        // mult: {partial, multiplier}; div: {rem, quotient}
    logic [WIDTH-1:0]     mcand_q, mcand_d; // multiplicand or divisor magnitude
    logic                 neg_q, neg_d;     // negate product / quotient in FIN
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 is_mult, is_multi, sgn, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag, alu_lo;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step, p_step;

`ifdef LAB5_MC_ALU_DIV_EN
    logic                 is_div;
    logic                 div_q, div_d;
    logic                 rneg_q, rneg_d;   // remainder takes dividend sign
    logic                 divz_q, divz_d;
    logic [WIDTH-1:0]     a_q, a_d;         // original dividend for divide-by-zero
    logic [2*WIDTH:0]     div_sh;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_step;

    assign is_div   = (op[3:1] == 3'b111);
    assign is_multi = is_mult | is_div;
    // Restoring step: shift {rem,quot} left, subtract divisor if it fits.
    assign div_sh   = {p_q, 1'b0};
    assign div_ge   = (div_sh[2*WIDTH:WIDTH] >= {1'b0, mcand_q});
    assign div_diff = div_sh[2*WIDTH-1:WIDTH] - mcand_q;
    assign div_step = div_ge ? {div_diff, div_sh[WIDTH-1:1], 1'b1} : div_sh[2*WIDTH-1:0];
    assign p_step   = div_q ? div_step : mul_step;
`else
    assign is_multi = is_mult;
    assign p_step   = mul_step;
`endif

    assign is_mult = (op[3:1] == 3'b011);
    assign sgn     = (op == 4'b0110) || (op == 4'b1110);
    assign a_neg   = sgn & a[WIDTH-1];
    assign b_neg   = sgn & b[WIDTH-1];
    assign a_mag   = a_neg ? -a : a;
    assign b_mag   = b_neg ? -b : b;

    // Shift-add step: conditionally add multiplicand to upper half, shift right.
    assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_step = {mul_sum, p_q[WIDTH-1:1]};

    always_comb begin
        alu_lo = '0;
        case (op)
            4'b0000: alu_lo = a & b;
            4'b0001: alu_lo = a | b;
            4'b0010: alu_lo = ~(a | b);
            4'b0011: alu_lo = a ^ b;
            4'b0100: alu_lo = a + b;
            4'b0101: alu_lo = a - b;
            4'b1000: alu_lo = b << shamt;
            4'b1001: alu_lo = b >> shamt;
            4'b1010,
            4'b1011: alu_lo = $signed(b) >>> shamt;
            4'b1100: alu_lo = WIDTH'($signed(a) < $signed(b));
            4'b1101: alu_lo = WIDTH'(a < b);
            default: alu_lo = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef LAB5_MC_ALU_DIV_EN
        div_d   = div_q;
        rneg_d  = rneg_q;
        divz_d  = divz_q;
        a_d     = a_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_multi) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        neg_d   = a_neg ^ b_neg;
                        p_d     = {{WIDTH{1'b0}}, b_mag};
                        mcand_d = a_mag;
`ifdef LAB5_MC_ALU_DIV_EN
                        div_d   = is_div;
                        rneg_d  = a_neg;
                        divz_d  = (b == '0);
                        a_d     = a;
                        if (is_div) begin
                            p_d     = {{WIDTH{1'b0}}, a_mag};
                            mcand_d = b_mag;
                        end
`endif
                    end else begin
                        hi_d   = '0;
                        lo_d   = alu_lo;
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                p_d   = p_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = S_FIN;
                    cnt_d   = '0;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
`ifdef LAB5_MC_ALU_DIV_EN
                if (div_q) begin
                    if (divz_q) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = neg_q  ? -p_q[WIDTH-1:0]       : p_q[WIDTH-1:0];
                        hi_d = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
                    end
                end else begin
                    {hi_d, lo_d} = neg_q ? -p_q : p_q;
                end
`else
                {hi_d, lo_d} = neg_q ? -p_q : p_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef LAB5_MC_ALU_DIV_EN
            div_q   <= 1'b0;
            rneg_q  <= 1'b0;
            divz_q  <= 1'b0;
            a_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef LAB5_MC_ALU_DIV_EN
            div_q   <= div_d;
            rneg_q  <= rneg_d;
            divz_q  <= divz_d;
            a_q     <= a_d;
`endif
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign zero      = (lo_q == '0);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lab5_mc_alu.sv
module tb_lab5_mc_alu;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 32-bit ----------------
  logic        start32 = 1'b0;
  logic [3:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [4:0]  sh32 = '0;
  logic [31:0] hi32, lo32;
  logic        zero32, busy32, done32;
  logic [1:0]  st32;

  lab5_mc_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
    .shamt(sh32), .hi(hi32), .lo(lo32), .zero(zero32), .busy(busy32),
    .done(done32), .dbg_state(st32)
  );

  // ---------------- DUT 8-bit ----------------
  logic       start8 = 1'b0;
  logic [3:0] op8 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [2:0] sh8 = '0;
  logic [7:0] hi8, lo8;
  logic       zero8, busy8, done8;
  logic [1:0] st8;

  lab5_mc_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .shamt(sh8), .hi(hi8), .lo(lo8), .zero(zero8), .busy(busy8),
    .done(done8), .dbg_state(st8)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp32_q[$];
  int          cyc32_q[$];
  logic [15:0] exp8_q[$];
  int          cyc8_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_lo32 = '0;
  int          last_issue8 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  logic [63:0] e32;
  logic [15:0] e8;
  int          c32, c8;

  always @(negedge clk) begin
    if (done32 === 1'b1) begin
      if (exp32_q.size() == 0) begin
        total++; bad++;
        $display("FAIL done32_unexpected: got done at cycle %0d expected none", cyc);
      end else begin
        e32 = exp32_q.pop_front();
        c32 = cyc32_q.pop_front();
        chk("res32", {hi32, lo32}, e32);
        chk("lat32", 64'(cyc), 64'(c32));
        chk("zero32", 64'(zero32), 64'(e32[31:0] == 32'h0));
        last_lo32 = e32[31:0];
      end
    end
    if (done8 === 1'b1) begin
      if (exp8_q.size() == 0) begin
        total++; bad++;
        $display("FAIL done8_unexpected: got done at cycle %0d expected none", cyc);
      end else begin
        e8 = exp8_q.pop_front();
        c8 = cyc8_q.pop_front();
        chk("res8", 64'({hi8, lo8}), 64'(e8));
        chk("lat8", 64'(cyc), 64'(c8));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue32(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sh, input logic [63:0] exp, input int lat);
    int waited = 0;
    @(negedge clk);
    while (busy32 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (busy32) begin
      total++; bad++;
      $display("FAIL issue32_timeout: got busy=1 expected busy=0");
      return;
    end
    op32 = o; a32 = av; b32 = bv; sh32 = sh; start32 = 1'b1;
    exp32_q.push_back(exp);
    cyc32_q.push_back(cyc + lat);
    @(posedge clk); #1;
    start32 = 1'b0;
    a32 = $urandom; b32 = $urandom;  // operand changes after accept must not matter
  endtask

  task automatic issue8(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp, input int lat);
    int waited = 0;
    @(negedge clk);
    while (busy8 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (busy8) begin
      total++; bad++;
      $display("FAIL issue8_timeout: got busy=1 expected busy=0");
      return;
    end
    op8 = o; a8 = av; b8 = bv; sh8 = '0; start8 = 1'b1;
    last_issue8 = cyc;
    exp8_q.push_back(exp);
    cyc8_q.push_back(cyc + lat);
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
  endtask

  // ---------------- stimulus ----------------
  int busy_cnt;
  int first8;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hi32", 64'(hi32), 64'h0);
    chk("rst_lo32", 64'(lo32), 64'h0);
    chk("rst_zero32", 64'(zero32), 64'h1);
    chk("rst_busy32", 64'(busy32), 64'h0);
    chk("rst_done32", 64'(done32), 64'h0);
    chk("rst_state32", 64'(st32), 64'h0);
    chk("rst_lo8", 64'(lo8), 64'h0);
    rst_n = 1'b1;

    // single-cycle ops
    issue32(4'b0100, 32'hFFFFFFFF, 32'h1, 5'd0, 64'h0, 1);
    issue32(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 64'h00000000_F000F000, 1);
    issue32(4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 64'h00000000_FFF0FFF0, 1);
    issue32(4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 64'h00000000_000F000F, 1);
    issue32(4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 64'h00000000_0FF00FF0, 1);
    issue32(4'b0101, 32'd5, 32'd7, 5'd0, 64'h00000000_FFFFFFFE, 1);
    issue32(4'b1000, 32'h0, 32'h1, 5'd31, 64'h00000000_80000000, 1);
    issue32(4'b1010, 32'h0, 32'h80000000, 5'd4, 64'h00000000_F8000000, 1);
    issue32(4'b1011, 32'h0, 32'h80000000, 5'd31, 64'h00000000_FFFFFFFF, 1);
    issue32(4'b1001, 32'h0, 32'h80000000, 5'd4, 64'h00000000_08000000, 1);
    issue32(4'b1100, 32'hFFFFFFFF, 32'h1, 5'd0, 64'h1, 1);
    issue32(4'b1101, 32'hFFFFFFFF, 32'h1, 5'd0, 64'h0, 1);

    // signed multiply with a start pulse while busy
    issue32(4'b0110, 32'hFFFFFFFD, 32'd7, 5'd0, 64'hFFFFFFFF_FFFFFFEB, 34);
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy32) break;
      busy_cnt++;
      start32 = (busy_cnt == 5);
      op32 = 4'b0100;
    end
    start32 = 1'b0;
    chk("busy_cycles32", 64'(busy_cnt), 64'd33);

    issue32(4'b0111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 64'hFFFFFFFE_00000001, 34);
    issue32(4'b0110, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 64'h00000000_00000001, 34);
    issue32(4'b0110, 32'h80000000, 32'd2, 5'd0, 64'hFFFFFFFF_00000000, 34);

`ifdef LAB5_MC_ALU_DIV_EN
    issue32(4'b1110, 32'hFFFFFFF9, 32'd2, 5'd0, 64'hFFFFFFFF_FFFFFFFD, 34);
    issue32(4'b1110, 32'd7, 32'hFFFFFFFE, 5'd0, 64'h00000001_FFFFFFFD, 34);
    issue32(4'b1110, 32'hFFFFFFF9, 32'd0, 5'd0, 64'hFFFFFFF9_FFFFFFFF, 34);
    issue32(4'b1110, 32'h80000000, 32'hFFFFFFFF, 5'd0, 64'h00000000_80000000, 34);
    issue32(4'b1111, 32'd100, 32'd7, 5'd0, 64'h00000002_0000000E, 34);
    issue32(4'b1111, 32'hFFFFFFFF, 32'h10, 5'd0, 64'h0000000F_0FFFFFFF, 34);
    issue32(4'b1111, 32'h12345678, 32'd0, 5'd0, 64'h12345678_FFFFFFFF, 34);
`else
    issue32(4'b1110, 32'hFFFFFFF9, 32'd2, 5'd0, 64'h0, 1);
    issue32(4'b1111, 32'd100, 32'd7, 5'd0, 64'h0, 1);
`endif

    // 8-bit unsigned multiply, restart in the done cycle
    issue8(4'b0111, 8'hFF, 8'hFF, 16'hFE01, 10);
    first8 = last_issue8;
    issue8(4'b0110, 8'h80, 8'h80, 16'h4000, 10);
    chk("b2b_gap8", 64'(last_issue8), 64'(first8 + 10));
    repeat (14) @(negedge clk);

    // reset in RUN cycle 10 of a multiply
    issue32(4'b0110, 32'd3, 32'd5, 5'd0, 64'h0, 34);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi32", 64'(hi32), 64'h0);
    chk("arst_lo32", 64'(lo32), 64'h0);
    chk("arst_zero32", 64'(zero32), 64'h1);
    chk("arst_busy32", 64'(busy32), 64'h0);
    chk("arst_state32", 64'(st32), 64'h0);
    void'(exp32_q.pop_back());   // aborted op produces no done
    void'(cyc32_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    issue32(4'b0100, 32'd2, 32'd3, 5'd0, 64'h5, 1);
    repeat (40) @(negedge clk);   // any late done from the aborted op would be flagged

    // drain and hold checks
    for (int i = 0; i < 200 && (exp32_q.size() != 0 || exp8_q.size() != 0); i++) @(negedge clk);
    chk("drain32", 64'(exp32_q.size()), 64'h0);
    chk("drain8", 64'(exp8_q.size()), 64'h0);
    repeat (3) @(negedge clk);
    chk("hold_lo32", 64'(lo32), 64'(last_lo32));
    chk("hold_done32", 64'(done32), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
